// File: rtl/tile_state_engine.sv
// tile_state_engine: active falling tile, preview queue and legality judge.
// After every spawn or update the engine walks JL, JR, JD and JROT. Each
// step places the board window at a candidate origin and tests it against
// the tile shape. Only IDLE accepts requests.

module tile_state_engine #(
  parameter int COORD_W       = 6,
  parameter int PREVIEW_DEPTH = 3,
  parameter int SPAWN_X       = 3,
  parameter int SPAWN_Y       = -2
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       empty_i,
  input  logic                       spawn_i,
  input  logic                       tile_type_v_i,
  input  logic [2:0]                 tile_type_i,
  input  logic [1:0]                 tile_angle_i,
  input  logic                       pos_v_i,
  input  logic [COORD_W-1:0]         new_x_i,
  input  logic [COORD_W-1:0]         new_y_i,
  input  logic                       rot_v_i,
  input  logic [4:0]                 rand_i,
  output logic [4:0]                 rom_addr_o,
  input  logic [15:0]                rom_shape_i,
  input  logic [1:0]                 rom_min_y_i,
  output logic [COORD_W-1:0]         mm_x_o,
  output logic [COORD_W-1:0]         mm_y_o,
  input  logic [15:0]                mm_data_i,
  output logic [COORD_W-1:0]         pos_x_o,
  output logic [COORD_W-1:0]         pos_y_o,
  output logic [2:0]                 type_o,
  output logic [1:0]                 angle_o,
  output logic [15:0]                shape_o,
  output logic [3:0]                 move_avail_o,
  output logic                       in_game_area_o,
  output logic [3*PREVIEW_DEPTH-1:0] preview_type_o,
  output logic [2*PREVIEW_DEPTH-1:0] preview_angle_o,
  output logic [15:0]                head_shape_o,
  output logic                       ready_o
);

  localparam int CNT_W = $clog2(PREVIEW_DEPTH + 1);
  localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(PREVIEW_DEPTH - 1);
  localparam logic [COORD_W-1:0] ONE_C    = COORD_W'(1);
  localparam logic [COORD_W-1:0] SPAWN_XC = COORD_W'(SPAWN_X);
  localparam logic [COORD_W-1:0] SPAWN_YC = COORD_W'(SPAWN_Y);

  typedef enum logic [2:0] {
    S_FILL  = 3'd0,
    S_HEAD  = 3'd1,
    S_IDLE  = 3'd2,
    S_SPAWN = 3'd3,
    S_JL    = 3'd4,
    S_JR    = 3'd5,
    S_JD    = 3'd6,
    S_JROT  = 3'd7
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [CNT_W-1:0]      r_count;
  logic [2:0]            r_q_type  [PREVIEW_DEPTH];
  logic [1:0]            r_q_angle [PREVIEW_DEPTH];
  logic [2:0]            r_type;
  logic [1:0]            r_angle;
  logic [COORD_W-1:0]    r_x;
  logic [COORD_W-1:0]    r_y;
  logic [15:0]           r_shape;
  logic [3:0]            r_move;
  logic                  r_in_game;
  logic [15:0]           r_head_shape;
  logic                  r_spawned;
  logic                  r_ready;

  logic                  w_upd;
  logic [2:0]            w_upd_type;
  logic [1:0]            w_upd_angle;
  logic [COORD_W-1:0]    w_upd_x;
  logic [COORD_W-1:0]    w_upd_y;
  logic [COORD_W-1:0]    w_cap_y;
  logic signed [COORD_W:0] w_ig_sum;
  logic                  w_in_game;
  logic [2:0]            w_rand_type;

  // Type 0 is not a playable tile; the generator's 0 maps to 7.
  function automatic logic [2:0] map_type(input logic [4:0] r);
    if (r[4:2] == 3'd0) begin
      map_type = 3'd7;
    end else begin
      map_type = r[4:2];
    end
  endfunction

  assign w_rand_type = map_type(rand_i);

  // Resolve the combined IDLE update; rotation overrides a loaded angle.
  always_comb begin
    w_upd       = tile_type_v_i | pos_v_i | rot_v_i;
    w_upd_type  = tile_type_v_i ? tile_type_i : r_type;
    w_upd_angle = r_angle;
    if (rot_v_i) begin
      w_upd_angle = r_angle + 2'd1;
    end else if (tile_type_v_i) begin
      w_upd_angle = tile_angle_i;
    end else begin
      w_upd_angle = r_angle;
    end
    w_upd_x  = pos_v_i ? new_x_i : r_x;
    w_upd_y  = pos_v_i ? new_y_i : r_y;
    w_cap_y  = (r_state == S_SPAWN) ? SPAWN_YC : w_upd_y;
    w_ig_sum = $signed({w_cap_y[COORD_W-1], w_cap_y})
             + $signed({{(COORD_W-1){1'b0}}, rom_min_y_i});
    w_in_game = ~w_ig_sum[COORD_W];
  end

  // Next-state selection; empty_i aborts everything except FILL/HEAD.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_FILL:  w_next_state = (r_count == LAST_CNT) ? S_HEAD : S_FILL;
      S_HEAD:  w_next_state = S_IDLE;
      S_IDLE: begin
        if (empty_i) begin
          w_next_state = S_IDLE;
        end else if (spawn_i) begin
          w_next_state = S_SPAWN;
        end else if (w_upd) begin
          w_next_state = S_JL;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_SPAWN: w_next_state = empty_i ? S_IDLE : S_JL;
      S_JL:    w_next_state = empty_i ? S_IDLE : S_JR;
      S_JR:    w_next_state = empty_i ? S_IDLE : S_JD;
      S_JD:    w_next_state = empty_i ? S_IDLE : S_JROT;
      S_JROT: begin
        if (empty_i) begin
          w_next_state = S_IDLE;
        end else if (r_spawned) begin
          w_next_state = S_HEAD;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_FILL;
    endcase
  end

  // Shape ROM address and board window origin for the current step.
  always_comb begin
    rom_addr_o = {r_q_type[0], r_q_angle[0]};
    mm_x_o     = r_x;
    mm_y_o     = r_y;
    case (r_state)
      S_IDLE: begin
        if (!empty_i && !spawn_i && w_upd) begin
          rom_addr_o = {w_upd_type, w_upd_angle};
        end else begin
          rom_addr_o = {r_q_type[0], r_q_angle[0]};
        end
      end
      S_JL:   begin rom_addr_o = {r_type, r_angle}; mm_x_o = r_x - ONE_C; end
      S_JR:   begin rom_addr_o = {r_type, r_angle}; mm_x_o = r_x + ONE_C; end
      S_JD:   begin rom_addr_o = {r_type, r_angle}; mm_y_o = r_y + ONE_C; end
      S_JROT: rom_addr_o = {r_type, r_angle + 2'd1};
      default: rom_addr_o = {r_q_type[0], r_q_angle[0]};
    endcase
  end

  // State register and registered ready flag.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= S_FILL;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_ready <= (w_next_state == S_IDLE);
    end
  end

  // Tile, queue and judge datapath; empty_i clears the current tile last.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_count      <= '0;
      r_type       <= 3'd0;
      r_angle      <= 2'd0;
      r_x          <= '0;
      r_y          <= '0;
      r_shape      <= 16'd0;
      r_move       <= 4'd0;
      r_in_game    <= 1'b0;
      r_head_shape <= 16'd0;
      r_spawned    <= 1'b0;
      for (int i = 0; i < PREVIEW_DEPTH; i++) begin
        r_q_type[i]  <= 3'd0;
        r_q_angle[i] <= 2'd0;
      end
    end else begin
      case (r_state)
        S_FILL: begin
          for (int i = 0; i < PREVIEW_DEPTH; i++) begin
            if (CNT_W'(i) == r_count) begin
              r_q_type[i]  <= w_rand_type;
              r_q_angle[i] <= rand_i[1:0];
            end
          end
          r_count <= r_count + CNT_W'(1);
        end
        S_HEAD: begin
          r_head_shape <= rom_shape_i;
          r_spawned    <= 1'b0;
        end
        S_IDLE: begin
          r_spawned <= 1'b0;
          if (!spawn_i && w_upd) begin
            r_type    <= w_upd_type;
            r_angle   <= w_upd_angle;
            r_x       <= w_upd_x;
            r_y       <= w_upd_y;
            r_shape   <= rom_shape_i;
            r_in_game <= w_in_game;
          end
        end
        S_SPAWN: begin
          if (!empty_i) begin
            r_type    <= r_q_type[0];
            r_angle   <= r_q_angle[0];
            r_x       <= SPAWN_XC;
            r_y       <= SPAWN_YC;
            r_shape   <= rom_shape_i;
            r_in_game <= w_in_game;
            r_spawned <= 1'b1;
            for (int i = 0; i < PREVIEW_DEPTH - 1; i++) begin
              r_q_type[i]  <= r_q_type[i+1];
              r_q_angle[i] <= r_q_angle[i+1];
            end
            r_q_type[PREVIEW_DEPTH-1]  <= w_rand_type;
            r_q_angle[PREVIEW_DEPTH-1] <= rand_i[1:0];
          end
        end
        S_JL:   r_move[0] <= ~|(mm_data_i & r_shape);
        S_JR:   r_move[1] <= ~|(mm_data_i & r_shape);
        S_JD:   r_move[2] <= ~|(mm_data_i & r_shape);
        S_JROT: r_move[3] <= ~|(mm_data_i & rom_shape_i);
        default: r_move <= r_move;
      endcase
      if (empty_i) begin
        r_type    <= 3'd0;
        r_angle   <= 2'd0;
        r_x       <= '0;
        r_y       <= '0;
        r_shape   <= 16'd0;
        r_move    <= 4'd0;
        r_in_game <= 1'b0;
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < PREVIEW_DEPTH; g++) begin : g_prev
      assign preview_type_o[3*g +: 3]  = r_q_type[g];
      assign preview_angle_o[2*g +: 2] = r_q_angle[g];
    end
  endgenerate

  assign pos_x_o        = r_x;
  assign pos_y_o        = r_y;
  assign type_o         = r_type;
  assign angle_o        = r_angle;
  assign shape_o        = r_shape;
  assign move_avail_o   = r_move;
  assign in_game_area_o = r_in_game;
  assign head_shape_o   = r_head_shape;
  assign ready_o        = r_ready;

endmodule

// File: tb/tb_tile_state_engine.sv
// Directed bench for tile_state_engine with a behavioural shape ROM and a
// board window that reads all-ones at one selectable origin.

module tb_tile_state_engine;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        empty, spawn, tt_v, pos_v, rot_v;
  logic [2:0]  tt;
  logic [1:0]  ta;
  logic [5:0]  nx, ny;
  logic [4:0]  rnd;
  logic [4:0]  rom_addr;
  logic [15:0] rom_shape;
  logic [1:0]  rom_min_y;
  logic [5:0]  mm_x, mm_y;
  logic [15:0] mm_data;
  logic [5:0]  px, py;
  logic [2:0]  ty;
  logic [1:0]  an;
  logic [15:0] shp;
  logic [3:0]  mv;
  logic        ig;
  logic [8:0]  pt;
  logic [5:0]  pa;
  logic [15:0] hs;
  logic        rdy;

  logic        blk_en;
  logic [5:0]  blk_x, blk_y;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          n;

  tile_state_engine dut (
    .clk_i(clk), .reset_n_i(reset_n), .empty_i(empty), .spawn_i(spawn),
    .tile_type_v_i(tt_v), .tile_type_i(tt), .tile_angle_i(ta),
    .pos_v_i(pos_v), .new_x_i(nx), .new_y_i(ny), .rot_v_i(rot_v),
    .rand_i(rnd), .rom_addr_o(rom_addr), .rom_shape_i(rom_shape),
    .rom_min_y_i(rom_min_y), .mm_x_o(mm_x), .mm_y_o(mm_y),
    .mm_data_i(mm_data), .pos_x_o(px), .pos_y_o(py), .type_o(ty),
    .angle_o(an), .shape_o(shp), .move_avail_o(mv),
    .in_game_area_o(ig), .preview_type_o(pt), .preview_angle_o(pa),
    .head_shape_o(hs), .ready_o(rdy)
  );

  always #5 clk = ~clk;

  // Shape ROM model: never empty, min_y follows address bit 0.
  function automatic logic [15:0] rom_fn(input logic [4:0] a);
    rom_fn = {a, 3'b101, a, 3'b011};
  endfunction

  assign rom_shape = rom_fn(rom_addr);
  assign rom_min_y = {1'b0, rom_addr[0]};
  assign mm_data   = (blk_en && mm_x == blk_x && mm_y == blk_y) ? 16'hFFFF : 16'h0000;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    empty = 1'b0; spawn = 1'b0; tt_v = 1'b0; pos_v = 1'b0; rot_v = 1'b0;
  endtask

  // Issue the requests already driven, then count cycles until ready.
  task automatic run_req(input string tag, input int exp_busy);
    tick();
    clear_reqs();
    n = 1;
    while (!rdy && n < 20) begin
      tick();
      if (!rdy) n++;
    end
    chk(tag, n, exp_busy);
  endtask

  initial begin
    reset_n = 1'b0;
    clear_reqs();
    tt = 3'd0; ta = 2'd0; nx = 6'd0; ny = 6'd0;
    rnd = 5'b00110;
    blk_en = 1'b0; blk_x = 6'd0; blk_y = 6'd0;
    tick(); tick();
    chk("rst_ready", rdy, 1'b0);
    chk("rst_type", ty, 3'd0);
    chk("rst_prev", pt, 9'd0);
    chk("rst_move", mv, 4'd0);

    reset_n = 1'b1;
    tick(); rnd = 5'b01001;
    tick(); rnd = 5'b00011;
    tick(); rnd = 5'b11100;
    chk("fill_ready_low", rdy, 1'b0);
    chk("fill_types", pt, {3'd7, 3'd2, 3'd1});
    chk("fill_angles", pa, {2'd3, 2'd1, 2'd2});
    tick();
    chk("ready_cycle5", rdy, 1'b1);
    chk("head_shape", hs, rom_fn(5'b00110));

    // Spawn the head tile.
    spawn = 1'b1; rnd = 5'b10100;
    run_req("spawn_latency", 6);
    chk("spawn_type", ty, 3'd1);
    chk("spawn_angle", an, 2'd2);
    chk("spawn_x", px, 6'd3);
    chk("spawn_y", py, 6'b111110);
    chk("spawn_ingame", ig, 1'b0);
    chk("spawn_shape", shp, rom_fn(5'b00110));
    chk("spawn_q_types", pt, {3'd5, 3'd7, 3'd2});
    chk("spawn_q_angles", pa, {2'd0, 2'd3, 2'd1});
    chk("spawn_head_shape", hs, rom_fn(5'b01001));
    chk("spawn_move", mv, 4'b1111);

    // Left window blocked.
    blk_en = 1'b1; blk_x = 6'b111111; blk_y = 6'd5;
    pos_v = 1'b1; nx = 6'd0; ny = 6'd5;
    run_req("pos_latency", 4);
    chk("pos_move", mv, 4'b1110);
    chk("pos_xy", {px, py}, {6'd0, 6'd5});
    chk("pos_ingame", ig, 1'b1);

    // Rotation target overlaps the window at the tile origin.
    blk_x = 6'd0; blk_y = 6'd5;
    rot_v = 1'b1;
    run_req("rot_latency", 4);
    chk("rot_move", mv, 4'b0111);
    chk("rot_angle", an, 2'd3);
    chk("rot_shape", shp, rom_fn(5'b00111));

    blk_en = 1'b0;
    rot_v = 1'b1;
    run_req("wrap_latency", 4);
    chk("wrap_angle", an, 2'd0);
    chk("wrap_move", mv, 4'b1111);

    // Type load with position; y=-1, min_y=1 sits exactly on the boundary.
    tt_v = 1'b1; tt = 3'd6; ta = 2'd3; pos_v = 1'b1; nx = 6'd2; ny = 6'b111111;
    run_req("load_latency", 4);
    chk("load_type", {ty, an}, {3'd6, 2'd3});
    chk("load_ingame", ig, 1'b1);
    chk("load_shape", shp, rom_fn(5'b11011));

    // empty_i during JR.
    pos_v = 1'b1;
    tick(); clear_reqs();
    tick();
    empty = 1'b1;
    tick();
    empty = 1'b0;
    chk("empty_ready", rdy, 1'b1);
    chk("empty_tile", {ty, an, px, py}, 17'd0);
    chk("empty_move", {mv, ig}, 5'd0);
    chk("empty_shape", shp, 16'd0);
    chk("empty_q", {pt, pa}, {3'd5, 3'd7, 3'd2, 2'd0, 2'd3, 2'd1});
    chk("empty_head", hs, rom_fn(5'b01001));

    // Spawn wins over a simultaneous position update.
    spawn = 1'b1; pos_v = 1'b1; nx = 6'd9; ny = 6'd9; rnd = 5'b00001;
    run_req("spawn2_latency", 6);
    chk("spawn2_pos", {px, py}, {6'd3, 6'b111110});
    chk("spawn2_tile", {ty, an}, {3'd2, 2'd1});
    chk("spawn2_q_types", pt, {3'd7, 3'd5, 3'd7});
    chk("spawn2_q_angles", pa, {2'd1, 2'd0, 2'd3});
    chk("spawn2_head", hs, rom_fn(5'b11111));

    // pos_v_i raised during JD must be dropped; right window blocked.
    blk_en = 1'b1; blk_x = 6'd2; blk_y = 6'd1;
    pos_v = 1'b1; nx = 6'd1; ny = 6'd1;
    tick(); clear_reqs();
    tick();
    tick();
    pos_v = 1'b1; nx = 6'd20; ny = 6'd20;
    tick(); clear_reqs();
    tick();
    chk("jd_ready", rdy, 1'b1);
    chk("jd_pos_ignored", {px, py}, {6'd1, 6'd1});
    chk("jd_move", mv, 4'b1101);
    tick();
    chk("jd_no_queue", rdy, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tile_state_engine.md
Name: tile_state_engine

Overview:
Holds the active falling tile (type, angle, position, shape) and a parametrised preview queue of upcoming tiles. After every position, rotation or spawn update, a fixed judge sequence queries the board matrix memory and reports left, right, down and rotate-clockwise legality to the game controller. It sits between the game FSM, the shape ROM, the board matrix memory and the random generator.

Parameters:
COORD_W, 6, signed width of each x/y coordinate
PREVIEW_DEPTH, 3, number of queued upcoming tiles (1..8)
SPAWN_X, 3, x given to a freshly spawned tile
SPAWN_Y, -2, y given to a freshly spawned tile (signed)

Ports:
clk_i  in  1  clock
reset_n_i  in  1  reset; asynchronous, active-low
empty_i  in  1  clear current tile (sync, highest priority)
spawn_i  in  1  pop preview head into the current tile
tile_type_v_i  in  1  direct load of current type/angle
tile_type_i  in  3  type for the direct load
tile_angle_i  in  2  angle for the direct load
pos_v_i  in  1  new position valid
new_x_i / new_y_i  in  COORD_W each  new position (signed)
rot_v_i  in  1  rotate current tile clockwise (angle+1 mod 4)
rand_i  in  5  random word from the generator, sampled when pushing
rom_addr_o  out  5  {type, angle} shape ROM address (combinational ROM)
rom_shape_i  in  16  4x4 shape bitmap
rom_min_y_i  in  2  first occupied row of the shape
mm_x_o / mm_y_o  out  COORD_W each  board window origin
mm_data_i  in  16  4x4 occupancy window, same cycle; out-of-board cells read as 1
pos_x_o / pos_y_o  out  COORD_W each  current position
type_o  out  3; angle_o  out  2; shape_o  out  16  current tile
move_avail_o  out  4  {rot, down, right, left} legality
in_game_area_o  out  1  y + min_y >= 0
preview_type_o  out  3*PREVIEW_DEPTH  entry 0 = head, in the LSBs
preview_angle_o  out  2*PREVIEW_DEPTH
head_shape_o  out  16  shape of preview entry 0
ready_o  out  1  high only in IDLE

Behaviour:
- States: FILL, HEAD, IDLE, SPAWN, JL, JR, JD, JROT.
- Reset (asynchronous assertion): all outputs and registers 0, queue count 0, state FILL. ready_o=0.
- FILL: one push per cycle of the mapped rand_i until count==PREVIEW_DEPTH, then HEAD.
- Mapping: type=rand_i[4:2], angle=rand_i[1:0]; type 0 is replaced by 7.
- HEAD: rom_addr_o = head {type,angle}; head_shape_o <= rom_shape_i; go to IDLE.
- IDLE priority: spawn_i > (tile_type_v_i | pos_v_i | rot_v_i). Requests outside IDLE are ignored; nothing is queued.
- spawn_i in IDLE → SPAWN:
  - current <= head; rom_addr_o = head; shape/min_y captured; pos <= (SPAWN_X, SPAWN_Y).
  - Queue shifts down by one; the mapped rand_i is pushed at the tail in the same cycle.
  - Then JL.
- Update in IDLE: tile_type_v_i loads type/angle; rot_v_i sets angle+1 and wins over tile_type_i's angle; pos_v_i loads the position. All apply in the same cycle. rom_addr_o = resulting {type,angle}; shape/min_y captured. Then JL.
- in_game_area_o is recomputed from the new y and new min_y in the same cycle (signed, COORD_W+1 bits).
- JL/JR/JD: mm origin = (x-1,y), (x+1,y), (x,y+1). move_avail_o bit <= ~|(mm_data_i & shape_o).
- JROT: mm origin = (x,y); rom_addr_o = {type, angle+1}; bit3 <= ~|(mm_data_i & rom_shape_i).
- After JROT: go to HEAD if a spawn occurred, otherwise IDLE. Judge latency is 4 cycles; after a spawn it is 6 cycles to ready.
- In IDLE, mm origin = (x,y); rom_addr_o = head address when no request is present.
- empty_i (sync): current type/angle/pos/shape, move_avail_o and in_game_area_o are set to 0. The preview queue and head_shape_o are kept. State goes to IDLE, unless it is FILL or HEAD, in which case that state is finished first.
- Coordinates are two's-complement with modulo 2^COORD_W wrap. The board is responsible for bounds via out-of-board=1.
- Reset mid-judge: queue count returns to 0 and a full refill follows.

Test Plan:
- Release reset with rand_i = 5'b00110, 5'b01001, 5'b00011, then 5'b11100 → after 3 FILL cycles preview types are (1,2,7) with angles (2,1,3). head_shape_o = ROM[1,2]. ready_o rises on cycle 5.
- spawn_i with rand_i = 5'b10100 → type_o=1, angle_o=2, pos=(3,-2). Queue becomes (2,7,5). ready_o returns after 6 cycles. in_game_area_o=0 when min_y=0.
- pos (0,5), mm_data_i all 1 only for the (-1,5) window → move_avail_o = 4'b1110.
- rot_v_i while shape[angle+1] overlaps the window → bit3=0 and angle_o is still updated. Separately, angle 3 + rot wraps to 0.
- empty_i during JR → type_o=0, move_avail_o=0, preview queue unchanged, ready_o=1 next cycle.
- pos_v_i and spawn_i in the same IDLE cycle → spawn wins and pos=(SPAWN_X,SPAWN_Y). pos_v_i during JD is ignored.
